ads8688_resp: RTL
=================

# ads8688_resp

SPI responder modelling the ADS8688 side of the manual-channel link: it decodes 16-bit commands sent by the SPI master, requests a conversion sample for the selected channel from a parallel sample source, and returns that sample in the data slot of the following frame. Runs in the system `clk` domain, oversampling `sclk`, `csn` and `mosi` through synchronisers. Used as the loopback/bench partner for the manual-channel controller and as an ADC stand-in on boards without the part. SPI mode 0 only: master samples MISO on `sclk` rise and shifts on `sclk` fall.

## Interface
- `FRAME_BITS`, 32: `sclk` rises per frame. The command occupies the first 16 bits; the data slot is the last 16 bits.
- `SYNC_STAGES`, 2: flip-flop stages on `sclk`, `csn` and `mosi`. Minimum value is 2.
- `clk` in, 1 bit: system clock; must run at ≥ 8× `sclk`.
- `arstn` in, 1 bit: asynchronous active-low reset.
- `sclk` in, 1 bit: SPI clock from the master, asynchronous to `clk`.
- `csn` in, 1 bit: chip select, active low.
- `mosi` in, 1 bit: command bits, MSB first.
- `miso` out, 1 bit: response bits, MSB first.
- `miso_oe` out, 1 bit: high while synchronised `csn` is low.
- `smp_req` out, 1 bit: sample request level.
- `smp_ch` out, 3 bits: channel for the pending request.
- `smp_data` in, 16 bits: sample value; accepted when `smp_valid` is high.
- `smp_valid` in, 1 bit: one-cycle sample strobe.
- `cmd_valid` out, 1 bit: 1-cycle pulse when a command is accepted.
- `cmd_word` out, 16 bits: last accepted command.
- `frame_err` out, 1 bit: 1-cycle pulse when a frame has a bad length (macro only).
- `data_miss` out, 1 bit: 1-cycle pulse when a frame starts with a request still pending.

## Operation
- **FSM states**
  - IDLE → SHIFT on synchronised `csn` fall.
  - SHIFT → DONE on `csn` rise.
  - DONE → IDLE after one cycle.
- **Entering SHIFT**
  - Bit counter is cleared to 0.
  - TX shift register is loaded with {16'h0000, `result`}.
  - `miso` = TX[31].
- **`sclk` rise in SHIFT**
  - The synchronised `mosi` bit is shifted into RX.
  - The bit counter increments, saturating at 63.
- **`sclk` fall in SHIFT**
  - TX shifts left by one and `miso` takes the new MSB.
  - Falls after the 32nd rise shift zeros.
- **DONE: the command is RX[31:16], i.e. the first 16 bits received.**
  - MAN_Ch_n (16'hC000 + n·16'h0400, n = 0..7): `chan` ← n, then issue a request.
  - NO_OP (16'h0000): issue a request on the current `chan`.
  - RST (16'h8500): `chan` ← 0 and `result` ← 0; no request.
  - Any other value: accepted into `cmd_word`; no request.
  - In every accepted case `cmd_valid` pulses and `cmd_word` is updated.
- **Request handshake**
  - Issuing a request sets `smp_req` = 1 and `smp_ch` = `chan`.
  - On `smp_valid` with `smp_req` = 1: `result` ← `smp_data`, and `smp_req` clears in the same cycle.
  - `smp_valid` while `smp_req` = 0 is ignored.
  - A new request while one is pending updates `smp_ch` and keeps `smp_req` = 1.
- **`data_miss`**
  - Pulses on a `csn` fall while `smp_req` = 1.
  - That frame carries the old `result`.
  - The request stays pending.
- **Outside SHIFT**
  - `sclk` edges are ignored.
  - `miso` = 0.
- **Reset mid-frame:** everything returns to reset values. The frame is lost; the next `csn` fall starts cleanly.
- **Reset values:** `miso` 0, `miso_oe` 0, `smp_req` 0, `smp_ch` 0, `cmd_valid` 0, `cmd_word` 16'h0000, `frame_err` 0, `data_miss` 0. Internal `chan` and `result` also reset to 0.

## Timing
- Detection latency: SYNC_STAGES + 1 `clk` cycles from a pin edge to its detected edge.
- `miso` update: valid ≤ SYNC_STAGES + 2 `clk` after `sclk` fall. This needs an `sclk` half-period ≥ 4 `clk`.
- Master setup: ≥ SYNC_STAGES + 2 `clk` from `csn` fall to the first `sclk` rise.
- After `csn` rise: `cmd_valid` and `smp_req` assert SYNC_STAGES + 2 `clk` later.
- Back-to-back frames: the sample source must answer before the next `csn` fall, otherwise `data_miss`.
- Simultaneous DONE request and `smp_valid` on the old request: the old data is stored, and the new request wins (`smp_req` stays 1).

## Configuration
- `ADS8688_RESP_FRAME_CHK_EN` defined: at DONE, a bit count ≠ FRAME_BITS pulses `frame_err`. The command is discarded: no `cmd_valid`, no request, no state change.
- Undefined:
  - Any frame with ≥ 16 rises is decoded.
  - Frames with < 16 rises are silently dropped.
  - `frame_err` is tied to 0.

## Structure
- `ads8688_pkg` holds:
  - the command constants (CMD_NO_OP, CMD_RST, CMD_MAN_CH_BASE, CMD_MAN_CH_STEP);
  - the FSM state enum;
  - the width constants (CMD_W = 16, DATA_W = 16).
- One sub-module, `spi_slv_sync`: synchronises `sclk`, `csn` and `mosi`, and produces `sclk_rise`, `sclk_fall`, `csn_fall` and `csn_rise` pulses.

## Test plan
- Frame with command 16'hC400, then a NO_OP frame with the source returning 16'hA5C3 → `smp_ch` = 1 after each frame; the second frame's MISO bits 16..31 = 16'hA5C3, bits 0..15 = 0.
- Command 16'hDC00 → `smp_ch` = 7 and `cmd_word` = 16'hDC00; `cmd_valid` pulses exactly once.
- Source withheld, two frames back-to-back → `data_miss` pulses at the second `csn` fall; that frame's MISO slot carries the previous `result`.
- RST 16'h8500 after a sample of 16'h1234 → the next frame's data slot is 16'h0000 and `smp_req` stays 0.
- Frame cut after 20 rises → `frame_err` pulse and no request when the macro is defined; decoded normally when it is not.
- `arstn` asserted at bit 10 → all outputs return to reset values; the following full C000 frame completes with `smp_ch` = 0.

Source files
------------

// File: rtl/ads8688_resp_pkg.sv
// ads8688_pkg: ADS8688 responder command codes, FSM state type and widths.
// Rev 1.0
`default_nettype none

package ads8688_pkg;

  localparam int CMD_W  = 16;
  localparam int DATA_W = 16;

  localparam logic [CMD_W-1:0] CMD_NO_OP       = 16'h0000;
  localparam logic [CMD_W-1:0] CMD_RST         = 16'h8500;
  localparam logic [CMD_W-1:0] CMD_MAN_CH_BASE = 16'hC000;
  localparam logic [CMD_W-1:0] CMD_MAN_CH_STEP = 16'h0400;
  localparam logic [CMD_W-1:0] CMD_MAN_CH_MASK = ~(CMD_MAN_CH_STEP * 16'd7);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  function automatic logic is_man_ch(input logic [CMD_W-1:0] cmd);
    return (cmd & CMD_MAN_CH_MASK) == CMD_MAN_CH_BASE;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ads8688_resp_if.sv
// ads8688_resp_if: SPI pins, sample-source handshake and command status of the responder.
// Rev 1.0
`default_nettype none

interface ads8688_resp_if;
  import ads8688_pkg::*;

  logic              sclk;
  logic              csn;
  logic              mosi;
  logic              miso;
  logic              miso_oe;
  logic              smp_req;
  logic [2:0]        smp_ch;
  logic [DATA_W-1:0] smp_data;
  logic              smp_valid;
  logic              cmd_valid;
  logic [CMD_W-1:0]  cmd_word;
  logic              frame_err;
  logic              data_miss;

  modport slave (
    input  sclk, csn, mosi, smp_data, smp_valid,
    output miso, miso_oe, smp_req, smp_ch, cmd_valid, cmd_word, frame_err, data_miss
  );

  modport master (
    output sclk, csn, mosi, smp_data, smp_valid,
    input  miso, miso_oe, smp_req, smp_ch, cmd_valid, cmd_word, frame_err, data_miss
  );

endinterface

`default_nettype wire

// File: rtl/ads8688_resp_spi_slv_sync.sv
// spi_slv_sync: synchronises sclk/csn/mosi into clk and flags their edges.
// Rev 1.0
`default_nettype none

module spi_slv_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  wire logic clk,
  input  wire logic arstn,
  input  wire logic sclk_i,
  input  wire logic csn_i,
  input  wire logic mosi_i,
  output logic      csn_o,
  output logic      mosi_o,
  output logic      sclk_rise_o,
  output logic      sclk_fall_o,
  output logic      csn_fall_o,
  output logic      csn_rise_o
);

  logic [SYNC_STAGES-1:0] sclk_sync_q;
  logic [SYNC_STAGES-1:0] csn_sync_q;
  logic [SYNC_STAGES-1:0] mosi_sync_q;
  logic                   sclk_prev_q;
  logic                   csn_prev_q;

  // csn chain resets high so a released reset never looks like a frame start
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      sclk_sync_q <= '0;
      csn_sync_q  <= '1;
      mosi_sync_q <= '0;
      sclk_prev_q <= 1'b0;
      csn_prev_q  <= 1'b1;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk_i};
      csn_sync_q  <= {csn_sync_q[SYNC_STAGES-2:0], csn_i};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi_i};
      sclk_prev_q <= sclk_sync_q[SYNC_STAGES-1];
      csn_prev_q  <= csn_sync_q[SYNC_STAGES-1];
    end
  end

  assign csn_o       = csn_sync_q[SYNC_STAGES-1];
  assign mosi_o      = mosi_sync_q[SYNC_STAGES-1];
  assign sclk_rise_o =  sclk_sync_q[SYNC_STAGES-1] & ~sclk_prev_q;
  assign sclk_fall_o = ~sclk_sync_q[SYNC_STAGES-1] &  sclk_prev_q;
  assign csn_fall_o  = ~csn_sync_q[SYNC_STAGES-1]  &  csn_prev_q;
  assign csn_rise_o  =  csn_sync_q[SYNC_STAGES-1]  & ~csn_prev_q;

endmodule

`default_nettype wire

// File: rtl/ads8688_resp.sv
// ads8688_resp: ADS8688 manual-channel SPI responder (mode 0) backed by a parallel sample source.
// Rev 1.0 -- define ADS8688_RESP_FRAME_CHK_EN to reject frames whose length differs from FRAME_BITS.
`default_nettype none

module ads8688_resp
  import ads8688_pkg::*;
#(
  parameter int FRAME_BITS  = 32,
  parameter int SYNC_STAGES = 2
) (
  input  wire logic      clk,
  input  wire logic      arstn,
  ads8688_resp_if.slave  bus
);

  logic csn_s, mosi_s, sclk_rise, sclk_fall, csn_fall, csn_rise;

  spi_slv_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk         (clk),
    .arstn       (arstn),
    .sclk_i      (bus.sclk),
    .csn_i       (bus.csn),
    .mosi_i      (bus.mosi),
    .csn_o       (csn_s),
    .mosi_o      (mosi_s),
    .sclk_rise_o (sclk_rise),
    .sclk_fall_o (sclk_fall),
    .csn_fall_o  (csn_fall),
    .csn_rise_o  (csn_rise)
  );

  state_e                state_q, state_d;
  logic [5:0]            cnt_q, cnt_d;
  logic [FRAME_BITS-1:0] tx_q, tx_d;
  logic [CMD_W-1:0]      rx_q, rx_d;
  logic [2:0]            chan_q, chan_d;
  logic [DATA_W-1:0]     result_q, result_d;
  logic                  smp_req_q, smp_req_d;
  logic [2:0]            smp_ch_q, smp_ch_d;
  logic                  cmd_valid_q, cmd_valid_d;
  logic [CMD_W-1:0]      cmd_word_q, cmd_word_d;
  logic                  data_miss_q, data_miss_d;
  logic                  frame_ok;
`ifdef ADS8688_RESP_FRAME_CHK_EN
  logic                  frame_err_q, frame_err_d;
`endif

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      tx_q        <= '0;
      rx_q        <= '0;
      chan_q      <= '0;
      result_q    <= '0;
      smp_req_q   <= 1'b0;
      smp_ch_q    <= '0;
      cmd_valid_q <= 1'b0;
      cmd_word_q  <= '0;
      data_miss_q <= 1'b0;
`ifdef ADS8688_RESP_FRAME_CHK_EN
      frame_err_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      tx_q        <= tx_d;
      rx_q        <= rx_d;
      chan_q      <= chan_d;
      result_q    <= result_d;
      smp_req_q   <= smp_req_d;
      smp_ch_q    <= smp_ch_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_word_q  <= cmd_word_d;
      data_miss_q <= data_miss_d;
`ifdef ADS8688_RESP_FRAME_CHK_EN
      frame_err_q <= frame_err_d;
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    tx_d        = tx_q;
    rx_d        = rx_q;
    chan_d      = chan_q;
    result_d    = result_q;
    smp_req_d   = smp_req_q;
    smp_ch_d    = smp_ch_q;
    cmd_valid_d = 1'b0;
    cmd_word_d  = cmd_word_q;
    data_miss_d = 1'b0;
    frame_ok    = 1'b0;
`ifdef ADS8688_RESP_FRAME_CHK_EN
    frame_err_d = 1'b0;
`endif

    // Sample capture first so a request issued in DONE below overrides the clear
    if (bus.smp_valid && smp_req_q) begin
      result_d  = bus.smp_data;
      smp_req_d = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        if (csn_fall) begin
          state_d     = ST_SHIFT;
          cnt_d       = '0;
          rx_d        = '0;
          tx_d        = FRAME_BITS'(result_q);
          data_miss_d = smp_req_q;
        end
      end
      ST_SHIFT: begin
        if (csn_rise) begin
          state_d = ST_DONE;
        end else begin
          if (sclk_rise) begin
            // RX freezes after 16 bits so it always holds the command slot
            if (cnt_q < 6'd16) rx_d = {rx_q[CMD_W-2:0], mosi_s};
            if (cnt_q != 6'd63) cnt_d = cnt_q + 6'd1;
          end
          if (sclk_fall) tx_d = {tx_q[FRAME_BITS-2:0], 1'b0};
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
`ifdef ADS8688_RESP_FRAME_CHK_EN
        frame_ok    = (cnt_q == 6'(FRAME_BITS));
        frame_err_d = ~frame_ok;
`else
        frame_ok    = (cnt_q >= 6'd16);
`endif
        if (frame_ok) begin
          cmd_valid_d = 1'b1;
          cmd_word_d  = rx_q;
          if (is_man_ch(rx_q)) begin
            chan_d    = rx_q[12:10];
            smp_req_d = 1'b1;
            smp_ch_d  = rx_q[12:10];
          end else if (rx_q == CMD_NO_OP) begin
            smp_req_d = 1'b1;
            smp_ch_d  = chan_q;
          end else if (rx_q == CMD_RST) begin
            chan_d   = '0;
            result_d = '0;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.miso      = (state_q == ST_SHIFT) ? tx_q[FRAME_BITS-1] : 1'b0;
  assign bus.miso_oe   = ~csn_s;
  assign bus.smp_req   = smp_req_q;
  assign bus.smp_ch    = smp_ch_q;
  assign bus.cmd_valid = cmd_valid_q;
  assign bus.cmd_word  = cmd_word_q;
  assign bus.data_miss = data_miss_q;
`ifdef ADS8688_RESP_FRAME_CHK_EN
  assign bus.frame_err = frame_err_q;
`else
  assign bus.frame_err = 1'b0;
`endif

endmodule

`default_nettype wire
